// File: rtl/serdes_tx_fifo_if.sv
// Byte-write / serial-output bundle for serdes_tx_fifo.
// Signal names match the legacy port list so existing connections carry over one-to-one.
interface serdes_tx_fifo_if;
    logic       WR_EN;
    logic [7:0] DIN;
    logic       FULL;
    logic [4:0] LEVEL;
    logic       OVF;
    logic       SOF_out;
    logic       SOUT;
    logic       BUSY;

    modport master (
        output WR_EN,
        output DIN,
        input  FULL,
        input  LEVEL,
        input  OVF,
        input  SOF_out,
        input  SOUT,
        input  BUSY
    );

    modport slave (
        input  WR_EN,
        input  DIN,
        output FULL,
        output LEVEL,
        output OVF,
        output SOF_out,
        output SOUT,
        output BUSY
    );
endinterface

// File: rtl/serdes_tx_fifo.sv
// Byte FIFO feeding an MSB-first serializer. Frames are sent back to back
// while data is queued; a write into a full FIFO is dropped and latches OVF.
module serdes_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    serdes_tx_fifo_if.slave bus
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_LVL = 5'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("serdes_tx_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level;
    logic          full;
    logic          ovf;
    logic [0:0]    state;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic          sof;
    logic          sout;
    logic          busy;

    logic          wr_acc;
    logic          pop;
    logic [4:0]    level_nxt;

    // Pop and write decisions both use the pre-edge LEVEL/FULL, so a byte
    // written this edge is only visible to the serializer from the next one.
    always_comb begin
        wr_acc    = bus.WR_EN && !full;
        pop       = (level != '0) && ((state == IDLE) || (bit_cnt == '0));
        level_nxt = level + {4'b0, wr_acc} - {4'b0, pop};
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) begin
            mem[wr_ptr] <= bus.DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full    <= 1'b0;
            ovf     <= 1'b0;
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            sof     <= 1'b0;
            sout    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == DEPTH_LVL);
            if (bus.WR_EN && full) begin
                ovf <= 1'b1;
            end

            // shreg holds the bits still to be sent, next one at [6].
            if (pop) begin
                state   <= SHIFT;
                bit_cnt <= 3'd7;
                shreg   <= mem[rd_ptr][6:0];
                sout    <= mem[rd_ptr][7];
                sof     <= 1'b1;
                busy    <= 1'b1;
            end else if (state == SHIFT && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 3'd1;
                shreg   <= {shreg[5:0], 1'b0};
                sout    <= shreg[6];
                sof     <= 1'b0;
            end else begin
                state   <= IDLE;
                bit_cnt <= '0;
                sout    <= 1'b0;
                sof     <= 1'b0;
                busy    <= 1'b0;
            end
        end
    end

    assign bus.FULL    = full;
    assign bus.LEVEL   = level;
    assign bus.OVF     = ovf;
    assign bus.SOF_out = sof;
    assign bus.SOUT    = sout;
    assign bus.BUSY    = busy;

    a_full_matches_level: assert property (@(posedge CLK) disable iff (RST)
        full == (level == DEPTH_LVL));
    a_level_bounded: assert property (@(posedge CLK) disable iff (RST)
        level <= DEPTH_LVL);
    a_idle_quiet: assert property (@(posedge CLK) disable iff (RST)
        (state == IDLE) |-> (!sof && !sout && !busy));
endmodule

// File: tb/tb_serdes_tx_fifo.sv
// Randomized and directed bench for serdes_tx_fifo against a queue-based
// transmit model; serial output is also reassembled into bytes and compared.
module tb_serdes_tx_fifo;
    localparam int unsigned DEPTH = 4;

    logic CLK = 1'b0;
    logic RST;

    serdes_tx_fifo_if bus ();

    serdes_tx_fifo #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: queued bytes, byte on the wire and its bit position (-1 = idle).
    logic [7:0] q [$];
    logic [7:0] cur;
    int         pos;
    logic       m_sof;
    logic       m_ovf;
    logic [7:0] exp_q [$];

    // Bytes reassembled from the serial output.
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;
    int         rx_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [7:0] d);
        logic acc;
        if (r) begin
            q.delete();
            pos   = -1;
            cur   = '0;
            m_sof = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        acc = w && (q.size() < DEPTH);
        if (w && !acc) m_ovf = 1'b1;
        if (pos <= 0) begin
            if (q.size() > 0) begin
                cur   = q.pop_front();
                pos   = 7;
                m_sof = 1'b1;
            end else begin
                pos   = -1;
                m_sof = 1'b0;
            end
        end else begin
            pos   = pos - 1;
            m_sof = 1'b0;
        end
        if (pos == 0) exp_q.push_back(cur);
        if (acc) q.push_back(d);
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] d);
        logic [31:0] exp_sout;
        RST       = r;
        bus.WR_EN = w;
        bus.DIN   = d;
        @(posedge CLK);
        model_edge(r, w, d);
        #1;
        exp_sout = (pos >= 0) ? 32'((cur >> pos) & 8'h01) : 32'd0;
        check("sof",   32'(bus.SOF_out), 32'(m_sof));
        check("sout",  32'(bus.SOUT),    exp_sout);
        check("busy",  32'(bus.BUSY),    32'(pos >= 0));
        check("level", 32'(bus.LEVEL),   32'(q.size()));
        check("full",  32'(bus.FULL),    32'(q.size() == DEPTH));
        check("ovf",   32'(bus.OVF),     32'(m_ovf));
        if (r) begin
            rx_bits = 0;
        end else if (bus.SOF_out) begin
            rx_byte = {7'b0, bus.SOUT};
            rx_bits = 1;
        end else if (rx_bits > 0) begin
            rx_byte = {rx_byte[6:0], bus.SOUT};
            rx_bits++;
        end
        if (rx_bits == 8) begin
            rx_q.push_back(rx_byte);
            rx_bits = 0;
        end
        RST       = 1'b0;
        bus.WR_EN = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_all();
        step(1'b1, 1'b0, 8'h00);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] burst [6];
        int         sof_seen;

        pos       = -1;
        cur       = '0;
        m_sof     = 1'b0;
        m_ovf     = 1'b0;
        rx_bits   = 0;
        rx_byte   = '0;
        RST       = 1'b1;
        bus.WR_EN = 1'b0;
        bus.DIN   = '0;

        reset_all();
        step(1'b1, 1'b1, 8'hAA);
        check("rst_level", 32'(bus.LEVEL), 32'd0);
        check("rst_busy",  32'(bus.BUSY),  32'd0);

        // Single byte
        step(1'b0, 1'b1, 8'h9B);
        step(1'b0, 1'b0, 8'h00);
        check("s1_sof", 32'(bus.SOF_out), 32'd1);
        idle(10);
        check("s1_idle_busy", 32'(bus.BUSY), 32'd0);
        check("s1_frames", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("s1_value", 32'(rx_q[0]), 32'h9B);
        compare_rx("s1");

        // Back to back
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h3C);
        idle(20);
        check("s2_level", 32'(bus.LEVEL), 32'd0);
        check("s2_frames", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("s2_first",  32'(rx_q[0]), 32'hA5);
            check("s2_second", 32'(rx_q[1]), 32'h3C);
        end
        compare_rx("s2");

        // Overflow: six consecutive writes, one dropped
        reset_all();
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, burst[i]);
        check("s3_ovf", 32'(bus.OVF), 32'd1);
        idle(50);
        check("s3_ovf_sticky", 32'(bus.OVF), 32'd1);
        check("s3_frames", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check("s3_order", 32'(rx_q[i]), 32'(burst[i]));
        compare_rx("s3");

        // Write coincident with a pop at LEVEL=2
        reset_all();
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        step(1'b0, 1'b1, 8'hC3);
        idle(6);
        check("s4_pre_level", 32'(bus.LEVEL), 32'd2);
        step(1'b0, 1'b1, 8'h01);
        check("s4_level", 32'(bus.LEVEL), 32'd2);
        check("s4_sof",   32'(bus.SOF_out), 32'd1);
        idle(30);
        check("s4_frames", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() > 0) check("s4_last", 32'(rx_q[rx_q.size() - 1]), 32'h01);
        compare_rx("s4");

        // Reset at bit 3 of 0xFF with two bytes queued
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        idle(3);
        check("s5_level_q", 32'(bus.LEVEL), 32'd2);
        check("s5_bit3",    32'(bus.SOUT),  32'd1);
        step(1'b1, 1'b0, 8'h00);
        check("s5_sout",  32'(bus.SOUT),  32'd0);
        check("s5_busy",  32'(bus.BUSY),  32'd0);
        check("s5_level", 32'(bus.LEVEL), 32'd0);
        check("s5_ovf",   32'(bus.OVF),   32'd0);
        sof_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.SOF_out) sof_seen++;
        end
        check("s5_no_sof", 32'(sof_seen), 32'd0);
        rx_q.delete();
        exp_q.delete();

        // Wrap-around: 20 bytes, one per 8 cycles
        reset_all();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(i));
            idle(7);
        end
        idle(12);
        check("s6_ovf", 32'(bus.OVF), 32'd0);
        check("s6_frames", 32'(rx_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++)
            check("s6_byte", 32'(rx_q[i]), 32'(i));
        compare_rx("s6");

        // Random traffic with varying load and occasional resets
        reset_all();
        for (int i = 0; i < 1500; i++) begin
            int unsigned load;
            load = (i / 250) % 3;
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b0, 8'h00);
            end else begin
                step(1'b0, ($urandom_range(0, 15) < (load * 4 + 1)), 8'($urandom));
            end
        end
        idle(8 * (DEPTH + 2));
        compare_rx("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
